// File: rtl/ln_calculator_vec.sv
// ln_calculator_vec
// Vector natural-log unit: N independent lanes, each taking a signed
// fixed-point operand (FRAC fractional bits) and producing ln(x) in the
// same format. All lanes share one valid pipeline. Fixed latency of three
// cycles after the sampling edge, one vector accepted every cycle.
//
// Ports
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset
//   i_valid  input vector valid (no backpressure)
//   i_data   N lanes x BIT_WIDTH signed operands, lane g at [g*BIT_WIDTH +: BIT_WIDTH]
//   o_ln     N lanes x BIT_WIDTH signed ln results, same packing as i_data
//   o_err    per-lane flag, set when the operand was <= 0
//   o_valid  o_ln / o_err carry a new result this cycle
//
// Pipeline ranks: operand register, normalisation (k, mantissa),
// ROM + interpolation (ln(m) at 16 fraction bits), combine/round/saturate.
// The output rank only loads on a valid result, so outputs hold during gaps.
module ln_calculator_vec #(
    parameter int N         = 4,
    parameter int BIT_WIDTH = 16,
    parameter int FRAC      = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [N*BIT_WIDTH-1:0] i_data,
    output logic [N*BIT_WIDTH-1:0] o_ln,
    output logic [N-1:0]           o_err,
    output logic                   o_valid
);

    // Mantissa fraction width: the leading one of a positive operand is
    // shifted up to bit BIT_WIDTH-1, leaving BIT_WIDTH-1 fraction bits.
    localparam int MF      = BIT_WIDTH - 1;
    localparam int REM_W   = MF - 6;
    localparam int PROD_W  = 16 + REM_W;
    localparam int K_W     = $clog2(BIT_WIDTH) + 2;
    localparam int SUM_W   = BIT_WIDTH + 8;
    localparam int LN_FRAC = 16;
    localparam int SH      = LN_FRAC - FRAC;

    // ln(2) at 16 fraction bits; the FRAC-bit constant is derived from it
    // by round-half-up, then re-expanded so k*LN2 stays an exact multiple
    // of the output LSB (powers of two come out exact).
    localparam logic [15:0] LN2_Q16 = 16'd45426;
    localparam int LN2 = (45426 + (1 << (SH - 1))) >> SH;
    localparam logic signed [SUM_W-1:0] LN2_EXT = SUM_W'(LN2 << SH);
    localparam logic signed [SUM_W-1:0] ROUND   = SUM_W'(1 << (SH - 1));
    localparam logic signed [BIT_WIDTH-1:0] LN_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic signed [BIT_WIDTH-1:0] LN_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};

    // round(ln(1 + i/64) * 65536), i = 0..63; the entry for i = 64 is ln(2).
    localparam logic [15:0] LN_ROM [64] = '{
        16'd0,     16'd1016,  16'd2017,  16'd3002,  16'd3973,  16'd4930,  16'd5873,  16'd6802,
        16'd7719,  16'd8623,  16'd9515,  16'd10394, 16'd11262, 16'd12119, 16'd12965, 16'd13800,
        16'd14624, 16'd15438, 16'd16242, 16'd17037, 16'd17821, 16'd18597, 16'd19364, 16'd20121,
        16'd20870, 16'd21611, 16'd22343, 16'd23067, 16'd23783, 16'd24492, 16'd25193, 16'd25886,
        16'd26573, 16'd27252, 16'd27924, 16'd28589, 16'd29248, 16'd29900, 16'd30546, 16'd31185,
        16'd31818, 16'd32445, 16'd33067, 16'd33682, 16'd34292, 16'd34896, 16'd35494, 16'd36087,
        16'd36675, 16'd37258, 16'd37835, 16'd38407, 16'd38975, 16'd39537, 16'd40095, 16'd40648,
        16'd41196, 16'd41740, 16'd42280, 16'd42815, 16'd43345, 16'd43872, 16'd44394, 16'd44912
    };

    // Shared valid pipeline: bit 0 = operand rank, bit 3 = output rank.
    logic [3:0] valid_q, valid_d;

    always_comb begin
        valid_d = {valid_q[2:0], i_valid};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign o_valid = valid_q[3];

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic signed [BIT_WIDTH-1:0] x_q, x_d;
        logic signed [K_W-1:0]       k1_q, k1_d, k2_q, k2_d;
        logic [MF-1:0]               frac1_q, frac1_d;
        logic                        err1_q, err1_d, err2_q, err2_d, err3_q, err3_d;
        logic [16:0]                 lnm2_q, lnm2_d;
        logic [BIT_WIDTH-1:0]        ln3_q, ln3_d;
        int                          msb;
        logic [5:0]                  idx;
        logic [REM_W-1:0]            rem;
        logic [15:0]                 rom_lo, rom_hi;
        logic [PROD_W-1:0]           prod;
        logic signed [SUM_W-1:0]     sum, rnd;

        always_comb begin
            x_d = i_data[g*BIT_WIDTH +: BIT_WIDTH];

            // Leading-one detect; the last hit in the loop is the MSB.
            // Non-positive operands are flagged and carry a zero mantissa.
            msb = 0;
            for (int b = 0; b < BIT_WIDTH - 1; b++) begin
                if (x_q[b]) msb = b;
            end
            err1_d  = (x_q <= 0);
            k1_d    = err1_d ? '0 : K_W'(msb - FRAC);
            frac1_d = err1_d ? '0 : MF'($unsigned(x_q) << (MF - msb));

            // Interpolate between adjacent ROM points using the low
            // mantissa bits; the top segment interpolates towards ln(2).
            idx    = frac1_q[MF-1 -: 6];
            rem    = frac1_q[REM_W-1:0];
            rom_lo = LN_ROM[idx];
            rom_hi = (idx == 6'd63) ? LN2_Q16 : LN_ROM[idx + 6'd1];
            prod   = PROD_W'(rom_hi - rom_lo) * PROD_W'(rem);
            lnm2_d = 17'(PROD_W'(rom_lo) + (prod >> REM_W));
            k2_d   = k1_q;
            err2_d = err1_q;

            // Combine at 16 fraction bits, round half-up, then saturate.
            sum = SUM_W'(k2_q) * LN2_EXT + SUM_W'(signed'({1'b0, lnm2_q}));
            rnd = (sum + ROUND) >>> SH;

            ln3_d  = ln3_q;
            err3_d = err3_q;
            if (valid_q[2]) begin
                err3_d = err2_q;
                if (err2_q) begin
                    ln3_d = LN_MIN;
                end else if (rnd < SUM_W'(LN_MIN)) begin
                    ln3_d = LN_MIN;
                end else if (rnd > SUM_W'(LN_MAX)) begin
                    ln3_d = LN_MAX;
                end else begin
                    ln3_d = rnd[BIT_WIDTH-1:0];
                end
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                x_q     <= '0;
                k1_q    <= '0;
                frac1_q <= '0;
                err1_q  <= 1'b0;
                k2_q    <= '0;
                lnm2_q  <= '0;
                err2_q  <= 1'b0;
                ln3_q   <= '0;
                err3_q  <= 1'b0;
            end else begin
                x_q     <= x_d;
                k1_q    <= k1_d;
                frac1_q <= frac1_d;
                err1_q  <= err1_d;
                k2_q    <= k2_d;
                lnm2_q  <= lnm2_d;
                err2_q  <= err2_d;
                ln3_q   <= ln3_d;
                err3_q  <= err3_d;
            end
        end

        assign o_ln[g*BIT_WIDTH +: BIT_WIDTH] = ln3_q;
        assign o_err[g]                       = err3_q;
    end

endmodule

// File: tb/tb_ln_calculator_vec.sv
// Testbench for ln_calculator_vec: directed vectors with hand-computed
// expected logarithms, gapped/back-to-back streams, reset behaviour and a
// random sweep checked against a real-valued ln reference.
module tb_ln_calculator_vec;

   localparam int N  = 4;
   localparam int BW = 16;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_valid;
   logic [N*BW-1:0] i_data;
   logic [N*BW-1:0] o_ln;
   logic [N-1:0]  o_err;
   logic          o_valid;

   typedef struct packed {
      logic [3:0][31:0] ln;
      logic [3:0][31:0] tol;
      logic [3:0]       err;
   } exp_t;

   int   total = 0;
   int   bad = 0;
   int   countIn = 0;
   int   countOut = 0;
   exp_t expQ[$];
   exp_t lastExp = '0;
   logic [3:0] vPipe = '0;

   ln_calculator_vec #(.N(N), .BIT_WIDTH(BW), .FRAC(12)) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_valid(i_valid),
      .i_data (i_data),
      .o_ln   (o_ln),
      .o_err  (o_err),
      .o_valid(o_valid)
   );

   // 10-unit clock period
   always #5 i_clk = ~i_clk;

   // Compare one observed value against its expectation within a tolerance
   task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
      int diff;
      diff = observed - expected;
      if (diff < 0) diff = -diff;
      total++;
      if (diff > tol) begin
         bad++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d tol=%0d at %0t", tag, observed, expected, tol, $time);
      end
   endtask

   function automatic exp_t mkExp(input int l0, input int l1, input int l2, input int l3,
                                  input int t0, input int t1, input int t2, input int t3,
                                  input logic [3:0] err);
      exp_t e;
      e.ln[0] = l0; e.ln[1] = l1; e.ln[2] = l2; e.ln[3] = l3;
      e.tol[0] = t0; e.tol[1] = t1; e.tol[2] = t2; e.tol[3] = t3;
      e.err = err;
      return e;
   endfunction

   function automatic logic [63:0] pack4(input int d0, input int d1, input int d2, input int d3);
      return {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
   endfunction

   // Real-valued reference: round(ln(x/4096)*4096), floored at -32768
   function automatic int refLn(input int x);
      real r;
      int  v;
      r = $ln(x / 4096.0) * 4096.0;
      v = int'(r);
      if (v < -32768) v = -32768;
      return v;
   endfunction

   // Drive one cycle of input on the falling edge; remember what a valid vector should produce
   task automatic applyStimulus(input logic v, input logic [63:0] data, input exp_t e);
      @(negedge i_clk);
      i_valid = v;
      i_data  = data;
      if (v) begin
         expQ.push_back(e);
         countIn++;
      end
   endtask

   // Expected o_valid timing: a vector sampled at edge T is due after edge T+3
   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) vPipe <= '0;
      else       vPipe <= {vPipe[2:0], i_valid};
   end

   // Every falling edge: either a due result or held/reset outputs
   always @(negedge i_clk) begin : monitor
      exp_t e;
      if (vPipe[3]) begin
         checkOutput("valid_hi", int'(o_valid), 1, 0);
         checkOutput("queue_nonempty", int'(expQ.size() > 0), 1, 0);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            for (int i = 0; i < N; i++)
               checkOutput($sformatf("ln%0d", i), int'(signed'(o_ln[i*BW +: BW])),
                           int'(signed'(e.ln[i])), int'(e.tol[i]));
            checkOutput("err", int'(o_err), int'(e.err), 0);
            lastExp = e;
            countOut++;
         end
      end else begin
         checkOutput("valid_lo", int'(o_valid), 0, 0);
         for (int i = 0; i < N; i++)
            checkOutput($sformatf("hold_ln%0d", i), int'(signed'(o_ln[i*BW +: BW])),
                        int'(signed'(lastExp.ln[i])), int'(lastExp.tol[i]));
         checkOutput("hold_err", int'(o_err), int'(lastExp.err), 0);
      end
   end

   // Directed sequences, reset scenarios and random sweep
   initial begin
      logic [63:0] junk;
      int d[4];
      junk = pack4(1, 1, 1, 1);

      // reset with i_valid held high: nothing may be captured
      i_rst   = 1'b1;
      i_valid = 1'b1;
      i_data  = pack4(4096, 8192, 11134, 32767);
      repeat (3) @(negedge i_clk);
      checkOutput("rst_valid", int'(o_valid), 0, 0);
      checkOutput("rst_err", int'(o_err), 0, 0);
      i_rst   = 1'b0;
      i_valid = 1'b0;
      repeat (2) applyStimulus(0, junk, '0);

      // single vector, including exact 1.0 and 2.0
      applyStimulus(1, pack4(4096, 8192, 11134, 32767), mkExp(0, 2839, 4096, 8517, 0, 0, 2, 2, 4'b0000));
      repeat (5) applyStimulus(0, junk, '0);

      // powers of two must be exact
      applyStimulus(1, pack4(16384, 2048, 1024, 512), mkExp(5678, -2839, -5678, -8517, 0, 0, 0, 0, 4'b0000));

      // back-to-back round-trip vectors
      applyStimulus(1, pack4(1591, 2925, 4096, 3434), mkExp(-3873, -1379, 0, -722, 2, 2, 0, 2, 4'b0000));
      applyStimulus(1, pack4(1426, 4096, 1185, 1715), mkExp(-4321, 0, -5080, -3567, 2, 0, 2, 2, 4'b0000));

      // boundary: zero, negative, saturating positive, smallest non-saturating
      applyStimulus(1, pack4(0, -5, 1, 2), mkExp(-32768, -32768, -32768, -31230, 0, 0, 0, 2, 4'b0011));
      repeat (4) applyStimulus(0, junk, '0);

      // gapped stream 1,0,1,1,0
      applyStimulus(1, pack4(6144, 12288, 20480, 3072), mkExp(1661, 4500, 6592, -1178, 2, 2, 2, 2, 4'b0000));
      applyStimulus(0, junk, '0);
      applyStimulus(1, pack4(10240, 24576, 4096, 8192), mkExp(3753, 7339, 0, 2839, 2, 2, 0, 0, 4'b0000));
      applyStimulus(1, pack4(28672, 14336, 5120, 2560), mkExp(7970, 5131, 914, -1925, 2, 2, 2, 2, 4'b0000));
      applyStimulus(0, junk, '0);
      repeat (5) applyStimulus(0, junk, '0);

      // asynchronous reset with vectors in flight and o_valid high
      applyStimulus(1, pack4(4096, 4096, 4096, 4096), mkExp(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
      applyStimulus(1, pack4(8192, 8192, 8192, 8192), mkExp(2839, 2839, 2839, 2839, 0, 0, 0, 0, 4'b0000));
      applyStimulus(1, pack4(16384, 16384, 16384, 16384), mkExp(5678, 5678, 5678, 5678, 0, 0, 0, 0, 4'b0000));
      applyStimulus(1, pack4(2048, 2048, 2048, 2048), mkExp(-2839, -2839, -2839, -2839, 0, 0, 0, 0, 4'b0000));
      @(posedge i_clk);
      #2;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      expQ.delete();
      lastExp = '0;
      #1;
      checkOutput("async_rst_valid", int'(o_valid), 0, 0);
      checkOutput("async_rst_ln0", int'(signed'(o_ln[BW-1:0])), 0, 0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      applyStimulus(1, pack4(4096, 8192, 16384, 2048), mkExp(0, 2839, 5678, -2839, 0, 0, 0, 0, 4'b0000));
      repeat (6) applyStimulus(0, junk, '0);

      // random sweep over [1, 32767], back-to-back
      countIn  = 0;
      countOut = 0;
      for (int n = 0; n < 10000; n++) begin
         for (int i = 0; i < N; i++) d[i] = int'($urandom_range(32767, 1));
         applyStimulus(1, pack4(d[0], d[1], d[2], d[3]),
                       mkExp(refLn(d[0]), refLn(d[1]), refLn(d[2]), refLn(d[3]), 2, 2, 2, 2, 4'b0000));
      end
      repeat (6) applyStimulus(0, junk, '0);
      checkOutput("count_in_out", countOut, countIn, 0);
      checkOutput("queue_empty", expQ.size(), 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ln_calculator_vec.md
LN_CALCULATOR_VEC -- requirements
Module: ln_calculator_vec

Interface
REQ-001 Parameter N, default 4, number of parallel lanes.
REQ-002 Parameter BIT_WIDTH, default 16, signed lane width.
REQ-003 Parameter FRAC, default 12, fractional bits (Q4.12 at defaults).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 i_clk  input  1  rising-edge clock.
REQ-006 i_rst  input  1  asynchronous active-high reset.
REQ-007 i_valid  input  1  input vector valid, one vector per asserted cycle, no backpressure.
REQ-008 i_data  input  N x BIT_WIDTH signed  Q4.12 operands, normally exp values in (0, 8).
REQ-009 o_ln  output  N x BIT_WIDTH signed  Q4.12 natural log per lane.
REQ-010 o_err  output  N x 1  per-lane flag: operand was <= 0.
REQ-011 o_valid  output  1  o_ln/o_err valid this cycle.

Function
REQ-012 Lanes SHALL be independent and identical; all lanes share one valid pipeline.
REQ-013 Fixed latency 3 cycles: vector sampled with i_valid=1 at edge T appears with o_valid=1 after edge T+3.
REQ-014 Full throughput: back-to-back i_valid accepted every cycle, with no bubbles and no reordering.
REQ-015 i_valid=0 cycles SHALL propagate as o_valid=0; outputs SHALL hold their last values while o_valid=0.
REQ-016 Stage 1: leading-one detect on positive x; k = position of MSB minus FRAC (range -12..+2); mantissa normalized to m in [1,2) with 15 fraction bits.
REQ-017 Stage 2: ln(m) SHALL come from a 64-entry ROM indexed by the top 6 mantissa fraction bits, linearly interpolated using the remaining bits; the result SHALL be carried at no fewer than 16 fraction bits.
REQ-018 Stage 3: result = k*LN2 + ln(m), with LN2 = 2839 (Q4.12), rounded half-up to FRAC bits.
REQ-019 Stage 3: results below -32768 SHALL saturate to -32768; results above 32767 SHALL saturate to 32767 (unreachable at defaults).
REQ-020 Accuracy: for x > 0 and no saturation, |o_ln - round(ln(x/4096)*4096)| <= 2 LSB.
REQ-021 For x = 4096 (1.0), o_ln SHALL be exactly 0; for x = 4096*2^j, o_ln SHALL be exactly round(j*2839.13), within 1 LSB.
REQ-022 For x <= 0, o_ln SHALL be -32768 and o_err=1; for x > 0, o_err=0, including saturated x.
REQ-023 Internal width: k*LN2 plus ln(m) SHALL be computed without overflow, at no less than BIT_WIDTH+4 bits, before saturation.

Reset
REQ-024 While i_rst=1: o_valid=0, o_ln all lanes 0, o_err all lanes 0, and all pipeline valid bits cleared, asynchronously.
REQ-025 Reset mid-operation: in-flight vectors SHALL be discarded and never emitted; the first vector after release SHALL follow REQ-013 timing.
REQ-026 An i_valid held high during reset SHALL be ignored; sampling SHALL begin on the first rising edge with i_rst=0.

Verification
REQ-027 Single vector {4096, 8192, 11134, 32767} -> 3 cycles later o_valid=1 for 1 cycle, o_ln={0, 2839, 4096+/-2, 8517+/-2}, o_err=0000.
REQ-028 Two back-to-back vectors {1591, 2925, 4096, 3434} and {1426, 4096, 1185, 1715} -> two consecutive o_valid cycles. Outputs {-3873, -1379, 0, -722} and {-4321, 0, -5080, -3567}, each lane within +/-2 LSB. This is a round-trip check against the exp table.
REQ-029 Boundary vector {0, -5, 1, 2} -> o_ln={-32768, -32768, -32768, -31230+/-2}, o_err={1,1,0,0}.
REQ-030 Gapped stream: valid pattern 1,0,1,1,0 -> o_valid pattern identical, delayed 3 cycles, with outputs held during gaps.
REQ-031 Reset asserted asynchronously between clock edges with 2 vectors in flight -> o_valid drops immediately, no stale vectors appear after release, and the next new vector is correct with latency 3.
REQ-032 Random sweep of 10000 vectors over [1, 32767] -> every lane within the REQ-020 tolerance (or saturated per REQ-019), with the valid count in equal to the valid count out.
